// File: rtl/multi_monitor.sv
// Multi-channel active-device counter with clamping, sticky clip flags and a hysteretic alarm; 1-cycle fully registered, no backpressure.
// Optional MONITOR_PEAK_EN adds a peak-hold register (peak_out) with peak_clr reload.
module multi_monitor #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int MAX_COUNT = 2**WIDTH-1,
  parameter int HI_THRESH = 200,
  parameter int LO_THRESH = 150
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] change,
  input  logic [CHANNELS-1:0] on_off,
  input  logic                err_clr,
  output logic [WIDTH-1:0]    counter_out,
  output logic                full,
  output logic                empty,
  output logic                alarm,
  output logic                overflow_err,
  output logic                underflow_err
`ifdef MONITOR_PEAK_EN
  ,
  output logic [WIDTH-1:0]    peak_out,
  input  logic                peak_clr
`endif
);

  localparam int CW = $clog2(CHANNELS+1);
  localparam int SW = WIDTH + CW + 1;
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX_COUNT);
  localparam logic [WIDTH-1:0]     MAX_W = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0]     HI_W  = WIDTH'(HI_THRESH);
  localparam logic [WIDTH-1:0]     LO_W  = WIDTH'(LO_THRESH);

  typedef enum logic {NORMAL, ALARM} state_t;
  state_t state;

  logic [CW-1:0]        ups, downs;
  logic signed [SW-1:0] raw;
  logic [WIDTH-1:0]     nxt;
  logic                 ovf, udf;

  // Sum is formed at SW bits so up to CHANNELS steps past either rail never wrap.
  always_comb begin
    ups   = '0;
    downs = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ups   = ups   + CW'(change[i] & on_off[i]);
      downs = downs + CW'(change[i] & ~on_off[i]);
    end
    raw = $signed({{(SW-WIDTH){1'b0}}, counter_out})
        + $signed({{(SW-CW){1'b0}}, ups})
        - $signed({{(SW-CW){1'b0}}, downs});
    ovf = 1'b0;
    udf = 1'b0;
    nxt = raw[WIDTH-1:0];
    if (raw[SW-1]) begin
      nxt = '0;
      udf = 1'b1;
    end else if (raw > MAX_S) begin
      nxt = MAX_W;
      ovf = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      counter_out   <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      state         <= NORMAL;
      alarm         <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      counter_out   <= nxt;
      full          <= (nxt == MAX_W);
      empty         <= (nxt == '0);
      // A clip in the same cycle as err_clr keeps the flag set.
      overflow_err  <= ovf | (overflow_err  & ~err_clr);
      underflow_err <= udf | (underflow_err & ~err_clr);
      case (state)
        NORMAL: if (nxt >= HI_W) begin
          state <= ALARM;
          alarm <= 1'b1;
        end
        ALARM: if (nxt <= LO_W) begin
          state <= NORMAL;
          alarm <= 1'b0;
        end
        default: begin
          state <= NORMAL;
          alarm <= 1'b0;
        end
      endcase
    end
  end

`ifdef MONITOR_PEAK_EN
  always_ff @(posedge clk) begin
    if (!rst)
      peak_out <= '0;
    else if (peak_clr || nxt > peak_out)
      peak_out <= nxt;
  end
`endif

endmodule

// File: tb/tb_multi_monitor.sv
// Directed bench for multi_monitor: a reference model pushes expected outputs to a scoreboard per step.
module tb_multi_monitor;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] change, on_off;
  logic       err_clr;
  logic [7:0] counter_out;
  logic       full, empty, alarm, overflow_err, underflow_err;
`ifdef MONITOR_PEAK_EN
  logic [7:0] peak_out;
  logic       peak_clr;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int cnt;
    bit full, empty, alarm, ovf, udf;
    int peak;
  } exp_t;
  exp_t sb[$];

  int m_cnt = 0, m_peak = 0;
  bit m_alarm = 0, m_ovf = 0, m_udf = 0;

  multi_monitor dut (
    .clk(clk), .rst(rst), .change(change), .on_off(on_off), .err_clr(err_clr),
    .counter_out(counter_out), .full(full), .empty(empty), .alarm(alarm),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
`ifdef MONITOR_PEAK_EN
    , .peak_out(peak_out), .peak_clr(peak_clr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] ch, input logic [3:0] oo, input bit ec, input bit r, input bit pc);
    int ups, downs, raw, nxt;
    bit clip_hi, clip_lo;
    exp_t e;
    if (!r) begin
      m_cnt = 0; m_alarm = 0; m_ovf = 0; m_udf = 0; m_peak = 0;
    end else begin
      ups = 0; downs = 0;
      for (int i = 0; i < 4; i++) begin
        if (ch[i] && oo[i]) ups++;
        if (ch[i] && !oo[i]) downs++;
      end
      raw = m_cnt + ups - downs;
      clip_hi = raw > 255;
      clip_lo = raw < 0;
      nxt = clip_hi ? 255 : (clip_lo ? 0 : raw);
      if (!m_alarm && nxt >= 200) m_alarm = 1;
      else if (m_alarm && nxt <= 150) m_alarm = 0;
      m_ovf = clip_hi || (m_ovf && !ec);
      m_udf = clip_lo || (m_udf && !ec);
      if (pc || nxt > m_peak) m_peak = nxt;
      m_cnt = nxt;
    end
    e.cnt = m_cnt; e.full = (m_cnt == 255); e.empty = (m_cnt == 0);
    e.alarm = m_alarm; e.ovf = m_ovf; e.udf = m_udf; e.peak = m_peak;
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] ch, input logic [3:0] oo,
                      input bit ec = 0, input bit r = 1, input bit pc = 0);
    exp_t e;
    rst = r; change = ch; on_off = oo; err_clr = ec;
`ifdef MONITOR_PEAK_EN
    peak_clr = pc;
`endif
    model(ch, oo, ec, r, pc);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("counter_out", 32'(counter_out), 32'(e.cnt));
      chk("full", 32'(full), 32'(e.full));
      chk("empty", 32'(empty), 32'(e.empty));
      chk("alarm", 32'(alarm), 32'(e.alarm));
      chk("overflow_err", 32'(overflow_err), 32'(e.ovf));
      chk("underflow_err", 32'(underflow_err), 32'(e.udf));
`ifdef MONITOR_PEAK_EN
      chk("peak_out", 32'(peak_out), 32'(e.peak));
`endif
    end
  endtask

  task automatic run(input int n, input logic [3:0] ch, input logic [3:0] oo);
    for (int i = 0; i < n; i++) step(ch, oo);
  endtask

  initial begin
    rst = 1'b0; change = '0; on_off = '0; err_clr = 1'b0;
`ifdef MONITOR_PEAK_EN
    peak_clr = 1'b0;
`endif
    #2;
    // Reset held with active events, then release.
    for (int i = 0; i < 3; i++) step(4'hF, 4'hF, 0, 0);
    chk("reset_count", 32'(counter_out), 0);
    chk("reset_empty", 32'(empty), 1);
    step(4'hF, 4'hF);
    chk("release_first", 32'(counter_out), 4);

    // Cancellation at 10.
    step(4'hF, 4'hF);
    step(4'b0011, 4'b0011);
    chk("at_ten", 32'(counter_out), 10);
    step(4'hF, 4'b0011);
    step(4'b0101, 4'b0001);
    step(4'h0, 4'h0);
    chk("cancel_hold", 32'(counter_out), 10);

    // Hysteresis.
    step(4'h0, 4'h0, 0, 0);
    run(50, 4'hF, 4'hF);
    chk("hyst_200", 32'(counter_out), 200);
    chk("hyst_alarm_on", 32'(alarm), 1);
    run(12, 4'hF, 4'h0);
    chk("hyst_152", 32'(counter_out), 152);
    chk("hyst_alarm_held", 32'(alarm), 1);
    step(4'hF, 4'h0);
    chk("hyst_148", 32'(counter_out), 148);
    chk("hyst_alarm_off", 32'(alarm), 0);

    // Saturation high and err_clr priority.
    step(4'h0, 4'h0, 0, 0);
    run(63, 4'hF, 4'hF);
    step(4'b0001, 4'b0001);
    chk("at_253", 32'(counter_out), 253);
    step(4'hF, 4'hF);
    chk("sat_255", 32'(counter_out), 255);
    chk("sat_full", 32'(full), 1);
    chk("sat_ovf", 32'(overflow_err), 1);
    step(4'h0, 4'h0, 1);
    chk("ovf_cleared", 32'(overflow_err), 0);
    step(4'hF, 4'hF, 1);
    chk("ovf_set_wins", 32'(overflow_err), 1);

    // Underflow, then mid-operation reset from alarm.
    step(4'h0, 4'h0, 0, 0);
    step(4'b0001, 4'b0001);
    step(4'hF, 4'h0);
    chk("udf_empty", 32'(empty), 1);
    chk("udf_flag", 32'(underflow_err), 1);
    run(50, 4'hF, 4'hF);
    run(5, 4'hF, 4'h0);
    chk("mid_180", 32'(counter_out), 180);
    chk("mid_alarm", 32'(alarm), 1);
    step(4'hF, 4'hF, 1, 0);
    chk("mid_rst_count", 32'(counter_out), 0);
    chk("mid_rst_alarm", 32'(alarm), 0);
    chk("mid_rst_udf", 32'(underflow_err), 0);

`ifdef MONITOR_PEAK_EN
    step(4'h0, 4'h0, 0, 0);
    run(30, 4'hF, 4'hF);
    run(20, 4'hF, 4'h0);
    chk("peak_120", 32'(peak_out), 120);
    step(4'h0, 4'h0, 0, 1, 1);
    chk("peak_clr_40", 32'(peak_out), 40);
`endif

    // Mixed traffic against the model.
    for (int i = 0; i < 200; i++)
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_monitor.md
# multi_monitor

Parametrised multi-channel successor to the single-input active IoT devices monitor. Tracks the number of active devices across `CHANNELS` event sources in one cycle, clamps the count to `[0, MAX_COUNT]`, and raises a hysteretic occupancy alarm. Sits between the per-zone device event decoders and the system status/interrupt logic.

## Interface
Parameters:
- `WIDTH`, 8: counter width in bits.
- `CHANNELS`, 4: number of independent event channels.
- `MAX_COUNT`, 2**WIDTH-1: saturation ceiling.
- `HI_THRESH`, 200: alarm assert level. Must satisfy `LO_THRESH < HI_THRESH <= MAX_COUNT`.
- `LO_THRESH`, 150: alarm release level.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous and active-low.
- `change`  in  CHANNELS  per-channel event strobe, one event per asserted bit per cycle.
- `on_off`  in  CHANNELS  per-channel direction: 1 = device joined (+1), 0 = device left (−1). Ignored where `change` is 0.
- `err_clr`  in  1  clears both sticky error flags.
- `counter_out`  out  WIDTH  active-device count.
- `full`  out  1  `counter_out == MAX_COUNT`.
- `empty`  out  1  `counter_out == 0`.
- `alarm`  out  1  hysteretic occupancy alarm.
- `overflow_err`  out  1  sticky; an increment was clipped at `MAX_COUNT`.
- `underflow_err`  out  1  sticky; a decrement was clipped at 0.
- `peak_out`  out  WIDTH  highest count since reset or `peak_clr`. Present only with `MONITOR_PEAK_EN`.
- `peak_clr`  in  1  reloads the peak from the current count. Present only with `MONITOR_PEAK_EN`.

## Operation
- Per-cycle step:
  - `ups = popcount(change & on_off)`.
  - `downs = popcount(change & ~on_off)`.
  - `raw = counter_out + ups − downs`, evaluated signed at `WIDTH + clog2(CHANNELS+1) + 1` bits. No intermediate wrap is permitted.
- Clamp:
  - `raw > MAX_COUNT` → next count is `MAX_COUNT`; set `overflow_err`.
  - `raw < 0` → next count is 0; set `underflow_err`.
  - Otherwise the next count is `raw`.
- Net zero: opposing events in the same cycle cancel; the count holds and no flag is set. All-zero `change` also holds.
- Alarm FSM, two states, evaluated on the next count:
  - `NORMAL` → `ALARM` when next count ≥ `HI_THRESH`.
  - `ALARM` → `NORMAL` when next count ≤ `LO_THRESH`.
  - Otherwise the state holds.
  - `alarm` = (state == `ALARM`).
- Sticky errors:
  - `err_clr` clears both flags.
  - If a new clip occurs in the same cycle as `err_clr`, the set wins.
- `full` and `empty` are decoded from the registered count.

## Timing
- Reset: `rst == 0` at a rising edge forces:
  - `counter_out = 0`, `empty = 1`, `full = 0`;
  - state `NORMAL`, `alarm = 0`;
  - both error flags 0;
  - `peak_out = 0`.
- Reset overrides every other input, including mid-operation and in the same cycle as events or `err_clr`.
- Latency: inputs sampled at edge k are reflected on all outputs immediately after edge k (1 cycle, fully registered). No combinational path from inputs to outputs.
- `alarm`, `full`, `empty` and the error flags update on the same edge as `counter_out`.
- Back-to-back events every cycle are supported. No handshake and no stall.

## Configuration
- `MONITOR_PEAK_EN` defined:
  - Adds `peak_out` and `peak_clr`.
  - Each edge, `peak_out = max(peak_out, next count)`.
  - `peak_clr` loads the next count instead.
  - Reset clears the peak to 0.
- `MONITOR_PEAK_EN` undefined: the ports and register are absent. All other behaviour is identical.

## Test plan
All scenarios use defaults: WIDTH=8, CHANNELS=4, HI=200, LO=150.
- Reset: `rst=0` for 3 cycles with `change=4'hF`, `on_off=4'hF` → `counter_out=0`, `empty=1`, `alarm=0`, errors 0. Release → first edge gives 4.
- Cancel: from 10, `change=4'hF`, `on_off=4'b0011` → stays 10 with no flags; `change=4'b0101`, `on_off=4'b0001` → also 10.
- Hysteresis: from 0, all-up for 50 cycles → 200 with `alarm=1` on that edge. All-down for 12 cycles → 152, `alarm=1`. One more → 148, `alarm=0`.
- Saturation high: from 253, all-up → 255, `full=1`, `overflow_err=1`. Next cycle hold plus `err_clr` → flag 0. `err_clr` together with another all-up → flag stays 1.
- Underflow and mid-op reset: from 1, all-down → 0, `empty=1`, `underflow_err=1`. From 180 with `alarm=1`, `rst=0` for one cycle → 0, `NORMAL`, flags 0.
- Peak (`MONITOR_PEAK_EN`): 0→120 up, then down to 40 → `peak_out=120`. `peak_clr` → 40. Without the macro, the bench compiles with the peak ports omitted.
